// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM stream reader.
// Holds the FSM encoding and the address-width helper.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bram_stream_reader_fifo2.sv
// Two-entry skid FIFO holding rows returned by the BRAM.
// Entry d0 is always the head; pops shift d1 down.
module skid_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] d0;
  logic [W-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      d0    <= '0;
      d1    <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) d0 <= din;
          else               d1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            d0 <= din;
          end else begin
            d0 <= d1;
            d1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = d0;
  assign valid = (count != 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read controller: issues BRAM reads with credit control
// and streams rows out through a 2-entry skid FIFO.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int RAM_WIDTH  = 128,
  parameter int RAM_DEPTH  = 256,
  parameter int ADDR_WIDTH = clogb2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]  doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RAM_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   pop_left;
  logic                  zdone;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  inflight;
  logic [1:0]            count;
  logic [2:0]            occ;

  // enb is the registered issue, so it doubles as the in-flight flag
  assign inflight = enb;
  assign pop      = m_valid && m_ready;
  assign occ      = {1'b0, count} + {2'b00, inflight};
  assign issue    = (state == READ) && (issue_left != LEN_ZERO)
                 && (occ < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept && (cmd_len != LEN_ZERO)) state_nxt = READ;
      READ:
        if (issue && (issue_left == LEN_ONE)) state_nxt = DRAIN;
      DRAIN:
        if (pop && (pop_left == LEN_ONE)) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    accept    = cmd_ready && cmd_valid;
    m_last    = m_valid && (pop_left == LEN_ONE);
    done      = zdone || (pop && (pop_left == LEN_ONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr    <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      enb        <= 1'b0;
      addrb      <= '0;
      zdone      <= 1'b0;
    end else begin
      enb   <= issue;
      zdone <= accept && (cmd_len == LEN_ZERO);
      if (accept) begin
        rd_addr    <= cmd_addr;
        issue_left <= cmd_len;
        pop_left   <= cmd_len;
      end else begin
        if (issue) begin
          addrb      <= rd_addr;
          rd_addr    <= (rd_addr == ADDR_MAX) ? '0 : rd_addr + 1'b1;
          issue_left <= issue_left - LEN_ONE;
        end
        if (pop) pop_left <= pop_left - LEN_ONE;
      end
    end
  end

  skid_fifo2 #(
    .W(RAM_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (doutb),
    .pop  (pop),
    .dout (m_data),
    .valid(m_valid),
    .count(count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader with a falling-edge BRAM model
// preloaded so that row i holds byte i replicated.
module tb_bram_stream_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   cmd_addr = '0;
  logic [8:0]   cmd_len = '0;
  logic         enb;
  logic [7:0]   addrb;
  logic [127:0] doutb;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         m_last;
  logic         done;

  int checks = 0;
  int failures = 0;

  logic [127:0] mem [256];

  always #5 clk = ~clk;

  always @(negedge clk) if (enb) doutb <= mem[addrb];

  bram_stream_reader dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .enb      (enb),
    .addrb    (addrb),
    .doutb    (doutb),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .done     (done)
  );

  typedef struct {
    logic [7:0] addr;
    logic [8:0] len;
    bit         rnd;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [127:0] row(input logic [7:0] r);
    return {16{r}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, " enb"}, 64'(enb), 64'd0);
    chk({tag, " addrb"}, 64'(addrb), 64'd0);
    chk({tag, " m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, " m_last"}, 64'(m_last), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " m_data"}, {63'd0, |m_data}, 64'd0);
  endtask

  task automatic run_burst(input logic [7:0] a, input logic [8:0] n,
                           input bit rnd, input int exp_done,
                           input string nm);
    int beats, enbs, dones, done_at, first_v;
    int data_err, last_err, stall_err, cr_err, extra;
    logic cr_after, prev_stall;
    logic [127:0] prev_data;
    logic [7:0] ra;
    beats = 0; enbs = 0; dones = 0; done_at = -1; first_v = -1;
    data_err = 0; last_err = 0; stall_err = 0; cr_err = 0; extra = 0;
    cr_after = 1'b0; prev_stall = 1'b0; prev_data = '0;
    @(posedge clk); #1;
    chk({nm, " ready before cmd"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n; m_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (enb) enbs++;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
      if (m_valid && first_v < 0) first_v = c;
      if (m_last && !m_valid) last_err++;
      if (dones == 0 && cmd_ready !== (n == 0)) cr_err++;
      if (m_valid && m_ready) begin
        ra = a + beats[7:0];
        if (beats >= int'(n)) extra++;
        else if (m_data !== row(ra)) data_err++;
        if (m_last !== (beats == int'(n) - 1)) last_err++;
        beats++;
      end
      if (dones > 0 && c == done_at + 1) begin
        cr_after = cmd_ready;
        break;
      end
      if (done) begin
        dones++;
        done_at = c;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      @(posedge clk); #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk({nm, " beats"}, 64'(beats), 64'(n));
    chk({nm, " enb count"}, 64'(enbs), 64'(n));
    chk({nm, " done pulses"}, 64'(dones), 64'd1);
    chk({nm, " data order"}, 64'(data_err), 64'd0);
    chk({nm, " extra beats"}, 64'(extra), 64'd0);
    chk({nm, " m_last"}, 64'(last_err), 64'd0);
    chk({nm, " stall stable"}, 64'(stall_err), 64'd0);
    chk({nm, " cmd_ready busy"}, 64'(cr_err), 64'd0);
    chk({nm, " cmd_ready after"}, 64'(cr_after), 64'd1);
    chk({nm, " first valid"}, 64'(first_v), (n == 0) ? 64'(-1) : 64'd2);
    if (exp_done >= 0)
      chk({nm, " done cycle"}, 64'(done_at), 64'(exp_done));
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 256; i++) mem[i] = row(i[7:0]);
    vecs[0] = '{8'h10, 9'd4,   1'b0, 5};
    vecs[1] = '{8'hFE, 9'd4,   1'b0, 5};
    vecs[2] = '{8'h20, 9'd8,   1'b1, -1};
    vecs[3] = '{8'h33, 9'd0,   1'b0, 0};
    vecs[4] = '{8'h00, 9'd256, 1'b0, 257};
    vecs[5] = '{8'h80, 9'd1,   1'b0, 2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    for (int v = 0; v < 6; v++)
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].rnd,
                vecs[v].exp_done, $sformatf("vec%0d", v));

    // reset in cycle 3 of a 16-row burst
    dn = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 8'h00; cmd_len = 9'd16; m_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dn++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) dn++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    chk("midrst no done", 64'(dn), 64'd0);
    run_burst(8'h40, 9'd2, 1'b0, 3, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the simple dual-port BRAM used as the unified buffer. It accepts a burst command (base row, row count), drives the BRAM read port (`enb`, `addrb`), absorbs the one-cycle read latency, and presents rows on a valid/ready stream toward the systolic array feeder. A 2-entry output buffer and credit check let it sustain one row per cycle under full throughput while tolerating arbitrary backpressure without losing or duplicating rows.

## Interface
Parameters:
- `RAM_WIDTH`, 128, row width in bits; matches the BRAM data width.
- `RAM_DEPTH`, 256, BRAM entries.
- `ADDR_WIDTH`, clog2(RAM_DEPTH), 8, BRAM address width.

Ports:
- `clk` in 1: single clock; reads on the BRAM port complete on the falling edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle; can accept a command.
- `cmd_addr` in ADDR_WIDTH: first row.
- `cmd_len` in ADDR_WIDTH+1: row count, 0..RAM_DEPTH.
- `enb` out 1: BRAM read enable.
- `addrb` out ADDR_WIDTH: BRAM read address.
- `doutb` in RAM_WIDTH: BRAM read data.
- `m_valid` out 1: stream row valid.
- `m_ready` in 1: consumer accepts.
- `m_data` out RAM_WIDTH: row data.
- `m_last` out 1: final row of burst.
- `done` out 1: one-cycle pulse when the last row is accepted, or for a zero-length command.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_addr` and `cmd_len` into `rd_addr`/`issue_left` and `pop_left`. If `cmd_len`=0, pulse `done` next cycle and stay in IDLE. Otherwise go to READ.
  - READ: issue reads while `issue_left`>0. Go to DRAIN when the last read is issued.
  - DRAIN: wait for the buffer to empty and `pop_left` to reach 0. On the last pop, pulse `done` and return to IDLE.
- Issue rule:
  - Issue in a cycle iff `issue_left`>0 and `count + inflight - pop < 2`, where `pop` = `m_valid && m_ready`.
  - An issue registers `enb`=1 and `addrb`=`rd_addr`. `rd_addr` then increments modulo RAM_DEPTH, wrapping 255→0, and `issue_left` decrements.
- `inflight` is set in the cycle after an issue. The following rising edge pushes `doutb` into the 2-entry FIFO.
- `m_data`/`m_valid` come from the FIFO head. `m_last` = (`pop_left`==1) && `m_valid`.
- A simultaneous push and pop leaves `count` unchanged. Order is strictly FIFO.
- `cmd_valid` outside IDLE is ignored; `cmd_ready`=0 there.
- `cmd_len`=RAM_DEPTH reads every row exactly once, starting at `cmd_addr`.

## Timing
- Reset values: `cmd_ready`=1, `enb`=0, `addrb`=0, `m_valid`=0, `m_last`=0, `done`=0, `m_data`=0. FIFO, `count`, `inflight`, and counters are cleared. State is IDLE.
- Reset mid-burst: in-flight and buffered rows are discarded, and `done` is not pulsed.
- Command accepted at edge 0 → `enb`=1 during cycle 1 → data captured at edge 2 → `m_valid`=1 from cycle 2.
- First-row latency is therefore 2 cycles.
- With `m_ready` held high, there is one row per cycle. An N-row burst has `done` high in cycle N+1 after acceptance, and `cmd_ready` returns the cycle after `done`.
- Backpressure: `m_valid`/`m_data` stay stable until accepted. At most 2 buffered plus 1 in-flight rows are never exceeded, so there is no overflow.
- `enb` is asserted only on issue cycles. `addrb` holds its last value otherwise.

## Structure
- Shared package: `clogb2` function and the FSM state encoding (IDLE/READ/DRAIN).
- One natural sub-module: `skid_fifo2`, the 2-entry RAM_WIDTH FIFO with `count`, push, and pop.
- The bench instantiates the existing BRAM, preloaded with row i = i replicated, to close the loop.

## Test plan
- `cmd_addr`=0x10, `cmd_len`=4, `m_ready`=1 → `m_valid` in cycles 2–5 with rows 0x10..0x13, `m_last` on 0x13, `done` in cycle 5.
- `cmd_addr`=0xFE, `cmd_len`=4 → rows 0xFE, 0xFF, 0x00, 0x01 in order (address wrap).
- `cmd_len`=8 with `m_ready` toggling in a random 50% pattern → all 8 rows delivered in order with no duplicates, `m_data` stable while stalled, and `enb` count = 8.
- `cmd_len`=0 → no `enb` and no `m_valid`; `done` pulses 1 cycle after acceptance; `cmd_ready` stays 1.
- `rst` asserted in cycle 3 of a 16-row burst → next cycle all outputs are at reset values; a new command `cmd_addr`=0x40, `cmd_len`=2 returns exactly 0x40, 0x41.
- `cmd_len`=256 with `m_ready`=1 → 256 beats, each row exactly once, `done` in cycle 257.
